// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared constants, state type and helpers for the pipeline
//               hazard/flush controller (stall vectors, flush causes,
//               ERET code, exception vector).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Exception type code that identifies ERET (return to EPC)
    localparam logic [31:0] c_eret_code  = 32'h0000_000e;
    // General exception entry vector
    localparam logic [31:0] c_exc_vector = 32'hBFC0_0380;

    localparam logic        c_flush      = 1'b1;
    // flush_cause encodings; Exception doubles as the idle value 0
    localparam logic        c_exception  = 1'b0;
    localparam logic        c_failed_bp  = 1'b1;

    // Per-stage hold vectors: bit0 ID/EX, bit1 EX/MEM, bit2 MEM/WB, bit3 WB
    localparam logic [3:0]  c_nostop     = 4'b0000;
    localparam logic [3:0]  c_stop_id    = 4'b0001;
    localparam logic [3:0]  c_stop_ex    = 4'b0011;
    localparam logic [3:0]  c_stop_mem   = 4'b0111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EXC_WAIT = 2'd1,
        ST_BR_WAIT  = 2'd2
    } state_t;

    // Redirect target for an exception: ERET returns to EPC, all else vectors
    function automatic logic [31:0] exc_target(input logic [31:0] etype,
                                               input logic [31:0] epc);
        return (etype == c_eret_code) ? epc : c_exc_vector;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline stall/flush controller. Resolves stage stall
//               requests into a per-stage hold vector, issues a one-cycle
//               flush with redirect PC for MEM exceptions and EX branch
//               mispredictions (deferring them while the relevant stages are
//               stalled), and counts stalled cycles.
// Ports       : clk, rst (sync, active low)
//               stallreq_id/ex/mem  - stage stall requests
//               exc_req, exc_type, cp0_epc - MEM-stage exception
//               bp_fail, bp_target  - EX-stage misprediction
//               stall[3:0], flush, flush_cause, new_pc, stall_cnt - outputs
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_req,
    input  logic [31:0] exc_type,
    input  logic [31:0] cp0_epc,
    input  logic        bp_fail,
    input  logic [31:0] bp_target,
    output logic [3:0]  stall,
    output logic        flush,
    output logic        flush_cause,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_exc_type;
    logic [31:0] r_exc_epc;
    logic [31:0] r_br_target;
    logic [31:0] r_stall_cnt;
    logic [3:0]  w_stall_req;
    logic        w_lat_exc;
    logic        w_lat_br;

    // Highest requesting stage wins
    always_comb begin
        w_stall_req = c_nostop;
        if (stallreq_mem)
            w_stall_req = c_stop_mem;
        else if (stallreq_ex)
            w_stall_req = c_stop_ex;
        else if (stallreq_id)
            w_stall_req = c_stop_id;
    end

    always_comb begin
        w_state_next = r_state;
        w_lat_exc    = 1'b0;
        w_lat_br     = 1'b0;
        stall        = w_stall_req;
        flush        = 1'b0;
        flush_cause  = c_exception;
        new_pc       = 32'h0;

        if (!rst) begin
            // Reset wins over everything, including pending events
            stall        = c_nostop;
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_EXC_WAIT: begin
                    // New exceptions/branches are ignored until MEM drains
                    if (!stallreq_mem) begin
                        flush        = c_flush;
                        flush_cause  = c_exception;
                        new_pc       = exc_target(r_exc_type, r_exc_epc);
                        stall        = c_nostop;
                        w_state_next = ST_RUN;
                    end else begin
                        stall = c_stop_mem;
                    end
                end
                default: begin
                    // RUN and BR_WAIT: an exception always takes priority
                    // and discards any branch (current or pending).
                    if (exc_req) begin
                        if (!stallreq_mem) begin
                            flush        = c_flush;
                            flush_cause  = c_exception;
                            new_pc       = exc_target(exc_type, cp0_epc);
                            stall        = c_nostop;
                            w_state_next = ST_RUN;
                        end else begin
                            w_lat_exc    = 1'b1;
                            w_state_next = ST_EXC_WAIT;
                        end
                    end else if (r_state == ST_BR_WAIT) begin
                        if (!stallreq_ex && !stallreq_mem) begin
                            flush        = c_flush;
                            flush_cause  = c_failed_bp;
                            new_pc       = r_br_target;
                            stall        = c_nostop;
                            w_state_next = ST_RUN;
                        end
                    end else if (bp_fail) begin
                        if (!stallreq_ex && !stallreq_mem) begin
                            flush       = c_flush;
                            flush_cause = c_failed_bp;
                            new_pc      = bp_target;
                            stall       = c_nostop;
                        end else begin
                            w_lat_br     = 1'b1;
                            w_state_next = ST_BR_WAIT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_exc_type  <= 32'h0;
            r_exc_epc   <= 32'h0;
            r_br_target <= 32'h0;
            r_stall_cnt <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_lat_exc) begin
                r_exc_type <= exc_type;
                r_exc_epc  <= cp0_epc;
            end
            if (w_lat_br)
                r_br_target <= bp_target;
            if ((stall != c_nostop) && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl. Each cycle's expected
//               outputs are queued when stimulus is applied, the DUT outputs
//               are sampled mid-cycle, and each scenario task drains and
//               compares both queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        exc_req, bp_fail;
    logic [31:0] exc_type, cp0_epc, bp_target;
    logic [3:0]  stall;
    logic        flush, flush_cause;
    logic [31:0] new_pc, stall_cnt;

    typedef struct packed {
        logic [3:0]  stall;
        logic        flush;
        logic        cause;
        logic [31:0] pc;
        logic [31:0] cnt;
    } obs_t;

    obs_t        sb[$];
    obs_t        obs[$];
    logic [31:0] exp_cnt = 32'h0;
    int          n_cmp = 0;
    int          n_fail = 0;

    localparam logic        E   = c_exception;
    localparam logic        B   = c_failed_bp;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exc_req(exc_req), .exc_type(exc_type), .cp0_epc(cp0_epc),
        .bp_fail(bp_fail), .bp_target(bp_target),
        .stall(stall), .flush(flush), .flush_cause(flush_cause),
        .new_pc(new_pc), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus away from the rising edge, queue the
    // expected outputs, then sample the DUT before the next edge.
    task automatic drive(input logic r, input logic id, input logic ex, input logic mem,
                         input logic exc, input logic [31:0] et, input logic [31:0] ep,
                         input logic bpf, input logic [31:0] bpt,
                         input logic [3:0] es, input logic ef, input logic ec,
                         input logic [31:0] epc_exp);
        obs_t e, o;
        @(negedge clk);
        rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
        exc_req = exc; exc_type = et; cp0_epc = ep; bp_fail = bpf; bp_target = bpt;
        e.stall = es; e.flush = ef; e.cause = ec; e.pc = epc_exp; e.cnt = exp_cnt;
        sb.push_back(e);
        if (!r)
            exp_cnt = 32'h0;
        else if (es != 4'b0000 && exp_cnt != 32'hFFFF_FFFF)
            exp_cnt = exp_cnt + 32'd1;
        #2;
        o.stall = stall; o.flush = flush; o.cause = flush_cause; o.pc = new_pc; o.cnt = stall_cnt;
        obs.push_back(o);
    endtask

    task automatic test_reset();
        obs_t e, g;
        int i = 0;
        drive(0, 1,1,1, 1, 32'h0e, 32'h1234, 1, 32'h55, 4'b0000, 0, 0, 32'h0);
        drive(0, 0,1,0, 0, 32'h0,  32'h0,    1, 32'h55, 4'b0000, 0, 0, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs.pop_front(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got stall=%b flush=%b cause=%b pc=%h cnt=%0d, expected stall=%b flush=%b cause=%b pc=%h cnt=%0d", i, g.stall, g.flush, g.cause, g.pc, g.cnt, e.stall, e.flush, e.cause, e.pc, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_stall_priority();
        obs_t e, g;
        int i = 0;
        drive(1, 1,0,0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0);
        drive(1, 1,1,0, 0, 0, 0, 0, 0, 4'b0011, 0, 0, 0);
        drive(1, 1,1,1, 0, 0, 0, 0, 0, 4'b0111, 0, 0, 0);
        drive(1, 0,0,1, 0, 0, 0, 0, 0, 4'b0111, 0, 0, 0);
        drive(1, 0,1,0, 0, 0, 0, 0, 0, 4'b0011, 0, 0, 0);
        drive(1, 0,0,0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        drive(1, 0,0,0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs.pop_front(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL stall_prio[%0d]: got stall=%b flush=%b cause=%b pc=%h cnt=%0d, expected stall=%b flush=%b cause=%b pc=%h cnt=%0d", i, g.stall, g.flush, g.cause, g.pc, g.cnt, e.stall, e.flush, e.cause, e.pc, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_exc_immediate();
        obs_t e, g;
        int i = 0;
        drive(1, 0,0,0, 1, 32'h0e, 32'h8000_1000, 0, 0, 4'b0000, 1, E, 32'h8000_1000);
        drive(1, 1,0,0, 1, 32'h04, 32'h8000_1000, 0, 0, 4'b0000, 1, E, VEC);
        drive(1, 0,0,0, 0, 32'h0e, 32'h8000_1000, 0, 0, 4'b0000, 0, 0, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs.pop_front(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL exc_immediate[%0d]: got stall=%b flush=%b cause=%b pc=%h cnt=%0d, expected stall=%b flush=%b cause=%b pc=%h cnt=%0d", i, g.stall, g.flush, g.cause, g.pc, g.cnt, e.stall, e.flush, e.cause, e.pc, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_exc_wait();
        obs_t e, g;
        int i = 0;
        // Non-ERET held by MEM for 3 cycles; new events while waiting ignored
        drive(1, 0,0,1, 1, 32'h04, 32'h1234_5678, 0, 0,     4'b0111, 0, 0, 0);
        drive(1, 0,0,1, 1, 32'h0e, 32'hDEAD_0000, 1, 32'h44, 4'b0111, 0, 0, 0);
        drive(1, 1,1,1, 0, 32'h0,  32'h0,         0, 0,     4'b0111, 0, 0, 0);
        drive(1, 0,0,0, 0, 32'h0e, 32'h0BAD_0000, 0, 0,     4'b0000, 1, E, VEC);
        drive(1, 0,0,0, 0, 32'h0,  32'h0,         0, 0,     4'b0000, 0, 0, 0);
        // ERET flushes to the EPC captured on entry, not the current one
        drive(1, 0,0,1, 1, 32'h0e, 32'h8000_2000, 0, 0,     4'b0111, 0, 0, 0);
        drive(1, 0,0,0, 0, 32'h0,  32'h1111_1111, 0, 0,     4'b0000, 1, E, 32'h8000_2000);
        drive(1, 0,0,0, 0, 32'h0,  32'h0,         0, 0,     4'b0000, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs.pop_front(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL exc_wait[%0d]: got stall=%b flush=%b cause=%b pc=%h cnt=%0d, expected stall=%b flush=%b cause=%b pc=%h cnt=%0d", i, g.stall, g.flush, g.cause, g.pc, g.cnt, e.stall, e.flush, e.cause, e.pc, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_branch();
        obs_t e, g;
        int i = 0;
        drive(1, 0,1,0, 0, 0, 0, 1, 32'h8000_0040, 4'b0011, 0, 0, 0);
        for (int k = 0; k < 4; k++)
            drive(1, 0,1,0, 0, 0, 0, 0, 32'h9999_0000, 4'b0011, 0, 0, 0);
        drive(1, 0,0,0, 0, 0, 0, 0, 32'h9999_0000, 4'b0000, 1, B, 32'h8000_0040);
        drive(1, 0,0,0, 0, 0, 0, 0, 32'h0,         4'b0000, 0, 0, 0);
        // Immediate redirect; the ID stall is suppressed by the flush
        drive(1, 1,0,0, 0, 0, 0, 1, 32'h8000_0100, 4'b0000, 1, B, 32'h8000_0100);
        // Deferred by a MEM stall
        drive(1, 0,0,1, 0, 0, 0, 1, 32'h0000_0200, 4'b0111, 0, 0, 0);
        drive(1, 0,0,0, 0, 0, 0, 0, 32'h0,         4'b0000, 1, B, 32'h0000_0200);
        drive(1, 0,0,0, 0, 0, 0, 0, 32'h0,         4'b0000, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs.pop_front(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL branch[%0d]: got stall=%b flush=%b cause=%b pc=%h cnt=%0d, expected stall=%b flush=%b cause=%b pc=%h cnt=%0d", i, g.stall, g.flush, g.cause, g.pc, g.cnt, e.stall, e.flush, e.cause, e.pc, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_simultaneous();
        obs_t e, g;
        int i = 0;
        drive(1, 0,0,0, 1, 32'h04, 0, 1, 32'h300, 4'b0000, 1, E, VEC);
        drive(1, 0,0,0, 0, 0,      0, 0, 32'h0,   4'b0000, 0, 0, 0);
        drive(1, 0,0,1, 1, 32'h04, 0, 1, 32'h300, 4'b0111, 0, 0, 0);
        drive(1, 0,0,0, 0, 0,      0, 0, 32'h0,   4'b0000, 1, E, VEC);
        drive(1, 0,0,0, 0, 0,      0, 0, 32'h0,   4'b0000, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs.pop_front(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL simultaneous[%0d]: got stall=%b flush=%b cause=%b pc=%h cnt=%0d, expected stall=%b flush=%b cause=%b pc=%h cnt=%0d", i, g.stall, g.flush, g.cause, g.pc, g.cnt, e.stall, e.flush, e.cause, e.pc, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_br_exc_override();
        obs_t e, g;
        int i = 0;
        drive(1, 0,1,0, 0, 0,      0,            1, 32'h8000_0040, 4'b0011, 0, 0, 0);
        drive(1, 0,1,0, 1, 32'h0e, 32'h8000_3000, 0, 0,            4'b0000, 1, E, 32'h8000_3000);
        drive(1, 0,0,0, 0, 0,      0,            0, 0,            4'b0000, 0, 0, 0);
        drive(1, 0,1,0, 0, 0,      0,            1, 32'h40,       4'b0011, 0, 0, 0);
        drive(1, 0,0,1, 1, 32'h04, 0,            0, 0,            4'b0111, 0, 0, 0);
        drive(1, 0,0,0, 0, 0,      0,            0, 0,            4'b0000, 1, E, VEC);
        drive(1, 0,0,0, 0, 0,      0,            0, 0,            4'b0000, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs.pop_front(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL br_exc_override[%0d]: got stall=%b flush=%b cause=%b pc=%h cnt=%0d, expected stall=%b flush=%b cause=%b pc=%h cnt=%0d", i, g.stall, g.flush, g.cause, g.pc, g.cnt, e.stall, e.flush, e.cause, e.pc, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_reset_in_wait();
        obs_t e, g;
        int i = 0;
        drive(1, 0,0,1, 1, 32'h04, 32'h5, 0, 0,     4'b0111, 0, 0, 0);
        drive(0, 0,0,1, 0, 0,      0,     0, 0,     4'b0000, 0, 0, 0);
        drive(1, 0,0,0, 0, 0,      0,     0, 0,     4'b0000, 0, 0, 0);
        drive(1, 0,0,0, 0, 0,      0,     0, 0,     4'b0000, 0, 0, 0);
        drive(1, 0,1,0, 0, 0,      0,     1, 32'h40, 4'b0011, 0, 0, 0);
        drive(0, 0,1,0, 0, 0,      0,     0, 0,     4'b0000, 0, 0, 0);
        drive(1, 0,0,0, 0, 0,      0,     0, 0,     4'b0000, 0, 0, 0);
        drive(1, 0,0,0, 0, 0,      0,     0, 0,     4'b0000, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs.pop_front(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_in_wait[%0d]: got stall=%b flush=%b cause=%b pc=%h cnt=%0d, expected stall=%b flush=%b cause=%b pc=%h cnt=%0d", i, g.stall, g.flush, g.cause, g.pc, g.cnt, e.stall, e.flush, e.cause, e.pc, e.cnt);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        int i = 0;
        drive(1, 0,0,0, 1, 32'h0e, 32'h8000_4000, 0, 0,            4'b0000, 1, E, 32'h8000_4000);
        drive(1, 0,0,0, 0, 0,      0,             1, 32'h8000_0500, 4'b0000, 1, B, 32'h8000_0500);
        drive(1, 0,0,0, 1, 32'h08, 32'h8000_4000, 0, 0,            4'b0000, 1, E, VEC);
        drive(1, 1,0,0, 0, 0,      0,             0, 0,            4'b0001, 0, 0, 0);
        drive(1, 0,0,0, 0, 0,      0,             0, 0,            4'b0000, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); g = obs.pop_front(); n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got stall=%b flush=%b cause=%b pc=%h cnt=%0d, expected stall=%b flush=%b cause=%b pc=%h cnt=%0d", i, g.stall, g.flush, g.cause, g.pc, g.cnt, e.stall, e.flush, e.cause, e.pc, e.cnt);
            end
            i++;
        end
    endtask

    initial begin
        rst = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        exc_req = 1'b0; exc_type = 32'h0; cp0_epc = 32'h0; bp_fail = 1'b0; bp_target = 32'h0;
        // Unchecked initial reset so the counter register is defined
        repeat (2) @(posedge clk);
        exp_cnt = 32'h0;
        test_reset();
        test_stall_priority();
        test_exc_immediate();
        test_exc_wait();
        test_branch();
        test_simultaneous();
        test_br_exc_override();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock.
REQ-002 rst  input  1  synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 stallreq_id  input  1  ID hazard stall (load-use).
REQ-004 stallreq_ex  input  1  EX multi-cycle stall (mul/div).
REQ-005 stallreq_mem  input  1  MEM stall (dcache busy).
REQ-006 exc_req  input  1  MEM-stage exception valid.
REQ-007 exc_type  input  32  exception type; 32'h0000000e = ERET.
REQ-008 cp0_epc  input  32  current CP0 EPC.
REQ-009 bp_fail  input  1  EX-stage branch misprediction.
REQ-010 bp_target  input  32  corrected branch target.
REQ-011 stall  output  4  per-stage hold: bit0 ID/EX, bit1 EX/MEM, bit2 MEM/WB, bit3 WB.
REQ-012 flush  output  1  one-cycle flush pulse (`Flush).
REQ-013 flush_cause  output  1  `Exception or `FailedBranchPrediction.
REQ-014 new_pc  output  32  redirect PC, valid while flush=1.
REQ-015 stall_cnt  output  32  stalled-cycle performance counter.

Function
REQ-016 stall SHALL be: stallreq_mem -> 4'b0111; else stallreq_ex -> 4'b0011; else stallreq_id -> 4'b0001; else 4'b0000 (highest requesting stage wins).
REQ-017 FSM SHALL have states RUN, EXC_WAIT, BR_WAIT.
REQ-018 RUN, exc_req=1, stallreq_mem=0: flush=1, flush_cause=`Exception in the same cycle (zero latency); stay RUN.
REQ-019 RUN, exc_req=1, stallreq_mem=1: latch exc_type and cp0_epc, enter EXC_WAIT, no flush.
REQ-020 RUN, bp_fail=1, exc_req=0: if stallreq_ex=0 and stallreq_mem=0, flush=1 cause `FailedBranchPrediction, new_pc=bp_target same cycle; else latch bp_target, enter BR_WAIT.
REQ-021 Simultaneous exc_req and bp_fail SHALL resolve as exception only; branch discarded.
REQ-022 EXC_WAIT: stall=4'b0111 until stallreq_mem=0; that cycle flush=1 with latched values, next state RUN; exc_req and bp_fail ignored while waiting.
REQ-023 BR_WAIT: stall per REQ-016; exc_req overrides per REQ-018/019 (latched branch discarded); else when stallreq_ex=0 and stallreq_mem=0, flush with latched target, next state RUN.
REQ-024 Exception new_pc SHALL be epc (current in RUN/BR_WAIT, latched in EXC_WAIT) when type is ERET, else 32'hBFC00380.
REQ-025 In any cycle with flush=1, stall SHALL be 4'b0000.
REQ-026 flush SHALL never be high two consecutive cycles from one event; flush=0 implies new_pc=0 and flush_cause=`Exception's complement-free default 0.
REQ-027 stall_cnt SHALL increment each cycle stall!=0, saturate at 32'hFFFFFFFF.

Reset
REQ-028 rst=0 SHALL force state RUN, latched type/epc/target to 0, stall_cnt=0, and outputs stall=0000, flush=0, flush_cause=0, new_pc=0 in that cycle.
REQ-029 Reset during EXC_WAIT or BR_WAIT SHALL discard the pending event; no flush after release.

Structure
REQ-030 ERET code, exception vector 32'hBFC00380, `Flush, `Exception, `FailedBranchPrediction, `Stop/`NoStop SHALL live in defines.v.
REQ-031 State encoding SHALL be local parameters; single module, no sub-module.

Verification
REQ-032 stallreq_ex=1, stallreq_id=1 -> stall=0011; stallreq_mem added -> 0111; stall_cnt +1 per cycle.
REQ-033 RUN, exc_req=1, exc_type=0x0e, cp0_epc=0x80001000, mem idle -> same-cycle flush=1, cause `Exception, new_pc=0x80001000, stall=0000.
REQ-034 exc_req=1 (type 0x04) with stallreq_mem=1 for 3 cycles -> stall=0111 three cycles, flush on 4th cycle, new_pc=0xBFC00380.
REQ-035 bp_fail=1, bp_target=0x8000_0040, stallreq_ex=1 for 5 cycles -> no flush, then flush cause `FailedBranchPrediction, new_pc=0x80000040.
REQ-036 BR_WAIT pending, exc_req=1 mem idle -> exception flush only; no later branch flush.
REQ-037 rst=0 asserted in EXC_WAIT -> all outputs zero; after release no flush until new event.
